// File: rtl/dst_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dst_serializer_pkg
//  Description : Shared types and constants for the dst column serializer and
//                its companion per-column input loader.
//                - state_e     : serializer FSM states (PAR only reachable when
//                                DST_SERIALIZER_PARITY_EN is defined)
//                - DST_NUM_COLS: default number of dst columns
//                - DST_COL_W   : default width of one dst column
//                - cnt_width() : bit counter width for a given frame length
//  Revision    : 1.0 - initial release
// ============================================================================
package dst_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_e;

  localparam int DST_NUM_COLS = 47;
  localparam int DST_COL_W    = 1;

  // The counter must be able to hold TOTAL_W (reached after the last data
  // bit when the parity bit follows), hence +1.
  function automatic int cnt_width(input int total_w);
    return $clog2(total_w + 1);
  endfunction

endpackage : dst_serializer_pkg
`default_nettype wire

// File: rtl/dst_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dst_serializer_if
//  Description : Capture/stream bus between the compressor dst outputs, the
//                serializer and the downstream observation pin.
//                dst_in    : flattened dst columns, column k at [k*COL_W +: COL_W]
//                capture   : one-cycle request to latch dst_in
//                out_data  : current serial bit
//                out_valid : out_data is valid
//                out_ready : downstream accepts the bit this cycle
//                out_last  : final bit of the frame
//                busy      : frame in progress
//                overrun   : sticky, a capture was dropped
//                modport master : source/observer side
//                modport slave  : serializer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface dst_serializer_if
  import dst_serializer_pkg::*;
#(
  parameter int NUM_COLS = DST_NUM_COLS,
  parameter int COL_W    = DST_COL_W
);

  localparam int TOTAL_W = NUM_COLS * COL_W;

  logic [TOTAL_W-1:0] dst_in;
  logic               capture;
  logic               out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
  logic               overrun;

  modport master (
    output dst_in, capture, out_ready,
    input  out_data, out_valid, out_last, busy, overrun
  );

  modport slave (
    input  dst_in, capture, out_ready,
    output out_data, out_valid, out_last, busy, overrun
  );

endinterface : dst_serializer_if
`default_nettype wire

// File: rtl/dst_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : dst_serializer
//  Description : Captures the parallel dst column bus in one cycle and streams
//                it out bit-serially, dst bit 0 first, over valid/ready.
//                Optional macro DST_SERIALIZER_PARITY_EN appends one even
//                parity bit (XOR of the frame) as the final, out_last bit.
//  Ports       : clk  - clock, all logic on posedge
//                rst  - synchronous active-high reset
//                bus  - dst_serializer_if.slave (dst_in, capture, out_ready in;
//                       out_data, out_valid, out_last, busy, overrun out)
//  Revision    : 1.0 - initial release
// ============================================================================
module dst_serializer
  import dst_serializer_pkg::*;
#(
  parameter int NUM_COLS = DST_NUM_COLS,
  parameter int COL_W    = DST_COL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  dst_serializer_if.slave      bus
);

  localparam int TOTAL_W = NUM_COLS * COL_W;
  localparam int CNT_W   = cnt_width(TOTAL_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_W - 1);

  state_e               state_q, state_d;
  logic [TOTAL_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 overrun_q, overrun_d;
`ifdef DST_SERIALIZER_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic xfer;        // bit accepted downstream this cycle
  logic last_data;   // currently presenting data bit TOTAL_W-1
  logic frame_end;   // final transfer of the frame happens this cycle
  logic load;        // capture accepted this cycle

  assign last_data = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
  assign xfer      = bus.out_valid && bus.out_ready;
  assign frame_end = xfer && bus.out_last;
  // A capture is only taken when idle or exactly on the final transfer, which
  // gives gap-free back-to-back frames.
  assign load      = bus.capture && ((state_q == ST_IDLE) || frame_end);

  // --------------------------------------------------------------------------
  // Outputs: all decoded from registered state, so they never depend
  // combinationally on out_ready or capture.
  // --------------------------------------------------------------------------
  assign bus.out_valid = (state_q != ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.overrun   = overrun_q;

`ifdef DST_SERIALIZER_PARITY_EN
  assign bus.out_last  = (state_q == ST_PAR);
  assign bus.out_data  = (state_q == ST_SHIFT) ? shreg_q[0] :
                         (state_q == ST_PAR)   ? parity_q   : 1'b0;
`else
  assign bus.out_last  = last_data;
  assign bus.out_data  = (state_q == ST_SHIFT) ? shreg_q[0] : 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
`ifdef DST_SERIALIZER_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (xfer) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_data) begin
`ifdef DST_SERIALIZER_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef DST_SERIALIZER_PARITY_EN
      ST_PAR: begin
        if (xfer) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An accepted capture overrides the frame-end return to IDLE.
    if (load) begin
      state_d = ST_SHIFT;
      shreg_d = bus.dst_in;
      cnt_d   = '0;
`ifdef DST_SERIALIZER_PARITY_EN
      parity_d = ^bus.dst_in;
`endif
    end

    if (bus.capture && !load) begin
      overrun_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
`ifdef DST_SERIALIZER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
`ifdef DST_SERIALIZER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule : dst_serializer
`default_nettype wire

// File: tb/tb_dst_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dst_serializer
//  Description : Self-checking bench for dst_serializer. A table of one-cycle
//                vectors covers reset and handshake basics; hand-written
//                sequences cover full frames, backpressure, back-to-back
//                frames, overrun, mid-frame reset and (with
//                DST_SERIALIZER_PARITY_EN) the parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dst_serializer;
  import dst_serializer_pkg::*;

  localparam int TW = DST_NUM_COLS * DST_COL_W;
`ifdef DST_SERIALIZER_PARITY_EN
  localparam int FL = TW + 1;
`else
  localparam int FL = TW;
`endif
  localparam logic [TW-1:0] ALL1 = {TW{1'b1}};

  logic clk;
  logic rst;

  dst_serializer_if #(.NUM_COLS(DST_NUM_COLS), .COL_W(DST_COL_W)) bus ();

  dst_serializer #(.NUM_COLS(DST_NUM_COLS), .COL_W(DST_COL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected output packing: {out_valid, out_data, out_last, busy, overrun}
  typedef struct {
    logic          rst;
    logic          cap;
    logic [TW-1:0] dst;
    logic          rdy;
    logic [4:0]    exp;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture a frame; first bit must be presented on the next cycle.
  task automatic start(input logic [TW-1:0] pat, input string tag);
    bus.dst_in    = pat;
    bus.capture   = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.capture   = 1'b0;
    bus.dst_in    = TW'({$urandom(), $urandom()});
    check({tag, "_start"}, {62'd0, bus.out_valid, bus.busy}, 64'd3);
  endtask

  // Receive bits b = 0 .. stop_at-1 of a frame carrying pat, checking every
  // presented bit. toggle: out_ready 1,0,1,0... ; cap_at: bit index at whose
  // transfer a capture of nxt is issued (-1 for none).
  task automatic rx(input logic [TW-1:0] pat, input bit toggle, input int cap_at,
                    input logic [TW-1:0] nxt, input int stop_at, input string tag);
    int   b   = 0;
    int   cyc = 0;
    logic rdy;
    logic expd;
    while (b < stop_at && cyc < 4 * FL) begin
      rdy  = toggle ? (cyc % 2 == 0) : 1'b1;
      expd = (b < TW) ? pat[b] : ^pat;
      check($sformatf("%s_bit%0d", tag, b),
            {61'd0, bus.out_valid, bus.out_data, bus.out_last},
            {61'd0, 1'b1, expd, (b == FL - 1)});
      bus.out_ready = rdy;
      bus.capture   = (b == cap_at) && rdy;
      bus.dst_in    = (b == cap_at) ? nxt : TW'({$urandom(), $urandom()});
      step();
      if (rdy) b++;
      cyc++;
    end
    bus.capture   = 1'b0;
    bus.out_ready = 1'b0;
    check({tag, "_bitcount"}, 64'(b), 64'(stop_at));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.capture   = 1'b0;
    bus.dst_in    = '0;
    bus.out_ready = 1'b0;

    //          rst  cap  dst          rdy   {v,d,l,busy,ovr}
    vecs[0] = '{1'b1, 1'b1, ALL1,      1'b1, 5'b00000};
    vecs[1] = '{1'b1, 1'b1, ALL1,      1'b1, 5'b00000};
    vecs[2] = '{1'b1, 1'b1, ALL1,      1'b1, 5'b00000};
    vecs[3] = '{1'b0, 1'b0, ALL1,      1'b1, 5'b00000};
    vecs[4] = '{1'b0, 1'b1, TW'(5),    1'b0, 5'b11010};
    vecs[5] = '{1'b0, 1'b0, '0,        1'b0, 5'b11010};
    vecs[6] = '{1'b0, 1'b0, '0,        1'b1, 5'b10010};
    vecs[7] = '{1'b0, 1'b0, '0,        1'b1, 5'b11010};
    vecs[8] = '{1'b0, 1'b1, ALL1,      1'b0, 5'b11011};
    vecs[9] = '{1'b1, 1'b0, '0,        1'b0, 5'b00000};

    for (int i = 0; i < 10; i++) begin
      rst           = vecs[i].rst;
      bus.capture   = vecs[i].cap;
      bus.dst_in    = vecs[i].dst;
      bus.out_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d", i),
            {59'd0, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.overrun},
            {59'd0, vecs[i].exp});
    end

    rst         = 1'b0;
    bus.capture = 1'b0;
    step();

    // Single frame, ready always high
    start(TW'(1), "single");
    rx(TW'(1), 1'b0, -1, '0, FL, "single");
    check("single_idle", {61'd0, bus.out_valid, bus.busy, bus.overrun}, 64'd0);

    // Backpressure: ready toggling, data must hold while ready is low
    start(TW'(48'h5555_5555_5555), "bp");
    rx(TW'(48'h5555_5555_5555), 1'b1, -1, '0, FL, "bp");
    check("bp_idle", {62'd0, bus.out_valid, bus.busy}, 64'd0);

    // Back-to-back: capture coincides with the final transfer
    start(TW'(48'h1234_5678_9ABC), "b2b1");
    rx(TW'(48'h1234_5678_9ABC), 1'b0, FL - 1, ALL1, FL, "b2b1");
    check("b2b_nobubble", {61'd0, bus.out_valid, bus.busy, bus.overrun}, 64'd6);
    rx(ALL1, 1'b0, -1, '0, FL, "b2b2");
    check("b2b_idle", {61'd0, bus.out_valid, bus.busy, bus.overrun}, 64'd0);

    // Overrun at bit 10, then reset at bit 20
    start(TW'(48'h0F0F_3C3C_A5A5), "ovr");
    rx(TW'(48'h0F0F_3C3C_A5A5), 1'b0, 10, ~TW'(48'h0F0F_3C3C_A5A5), 20, "ovr");
    check("ovr_sticky", {63'd0, bus.overrun}, 64'd1);
    rst = 1'b1;
    step();
    check("rst_midframe", {61'd0, bus.out_valid, bus.busy, bus.overrun}, 64'd0);
    rst = 1'b0;
    step();
    check("rst_release", {61'd0, bus.out_valid, bus.busy, bus.overrun}, 64'd0);

`ifdef DST_SERIALIZER_PARITY_EN
    // Parity bit: ^7 = 1, ^3 = 0
    start(TW'(7), "par7");
    rx(TW'(7), 1'b0, -1, '0, FL - 1, "par7");
    check("par7_final", {62'd0, bus.out_data, bus.out_last}, 64'd3);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("par7_idle", {63'd0, bus.out_valid}, 64'd0);
    start(TW'(3), "par3");
    rx(TW'(3), 1'b0, -1, '0, FL, "par3");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dst_serializer
`default_nettype wire
